wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master Wishbone arbiter that shares the single system bus (RAM_BIOS, I/O decoder, ACK and read-data muxes) between the S86 processor (master 0) and a second bus master such as a DMA or program-load engine (master 1). It sits between the masters and the existing slave-side fabric:
- arbitrates on `cyc` with round-robin priority;
- holds the grant for a whole bus cycle;
- routes request signals to the slave side and responses back to the granted master only.

## Interface
Parameters:
- `TIMEOUT`, default 255: slave-response watchdog limit in clocks, used only with `ARB_TIMEOUT_EN`; legal range 2..65535.

Ports:
- `wb_clk_i`  in  1  system clock; all state changes on its rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `m0_adr_i` / `m1_adr_i`  in  19  master word address [19:1].
- `m0_dat_i` / `m1_dat_i`  in  16  master write data.
- `m0_sel_i` / `m1_sel_i`  in  2  byte selects.
- `m0_we_i`, `m0_tga_i`, `m0_stb_i`, `m0_cyc_i` / same for `m1_`  in  1 each  write enable, I/O tag, strobe, cycle.
- `m0_dat_o` / `m1_dat_o`  out  16  read data returned to the master.
- `m0_ack_o` / `m1_ack_o`  out  1  acknowledge to the master.
- `s_adr_o`  out  19; `s_dat_o`  out  16; `s_sel_o`  out  2  slave-side address, write data, byte selects.
- `s_we_o`, `s_tga_o`, `s_stb_o`, `s_cyc_o`  out  1 each  slave-side controls.
- `s_dat_i`  in  16  slave read data.
- `s_ack_i`  in  1  slave acknowledge.
- `gnt_o`  out  2  one-hot grant: bit0 = M0, bit1 = M1.
- `arb_err_o`  out  1  one-clock pulse on watchdog expiry.

## Operation
State machine, registered: IDLE, GNT0, GNT1.

Transitions out of IDLE:
- Only `m0_cyc_i` high -> GNT0.
- Only `m1_cyc_i` high -> GNT1.
- Both high -> the master not named by the priority pointer loses. Pointer resets to M0 and flips to the other master whenever a grant is issued.

Holding and releasing a grant:
- GNTx holds while `mx_cyc_i` = 1. Bus locks across multi-stb bursts, e.g. read-modify-write.
- GNTx with `mx_cyc_i` = 0 and the other master's `cyc` = 1 -> direct handover to the other grant, no IDLE bubble.
- GNTx with `mx_cyc_i` = 0 and the other master idle -> IDLE.

Routing:
- Slave outputs are a combinational mux of the granted master's `adr/dat/sel/we/tga`.
- `s_stb_o` = granted `stb` AND grant; `s_cyc_o` = granted `cyc` AND grant.
- In IDLE, `s_stb_o` = `s_cyc_o` = 0 and `adr/dat/sel/we/tga` drive 0.
- `mx_ack_o` = `s_ack_i` AND `gnt_o[x]`.
- Both `mx_dat_o` carry `s_dat_i`.
- An ungranted master never sees `ack`.

Other rules:
- A `cyc` falling in the same clock as `s_ack_i` is legal; the ack is delivered and the grant is released on the next edge.
- Reset in mid-cycle: state -> IDLE, grant drops, and slave `stb/cyc` are 0 on the next clock. The in-flight transfer is abandoned with no ack.

## Timing
Reset values:
- `gnt_o` = 00, state IDLE, priority pointer = M0.
- `s_cyc_o` = `s_stb_o` = 0, `m0_ack_o` = `m1_ack_o` = 0, `arb_err_o` = 0.

Latencies:
- Arbitration: 1 clock. `cyc` sampled high at edge N means grant and slave strobe are visible after edge N.
- Ack path from slave to master: combinational, 0 clocks added.
- Handover: the new master's signals reach the slave the clock after the old `cyc` is sampled low.
- Masters must keep `adr/we/sel/dat` stable from `stb` until ack.

## Configuration
Macro `ARB_TIMEOUT_EN` (watchdog).

With `ARB_TIMEOUT_EN` defined:
- A 16-bit counter runs while `s_stb_o` = 1 and `s_ack_i` = 0, and clears on ack, on `stb` low, on grant change and on reset.
- When the count reaches `TIMEOUT`, the arbiter does all of the following for one clock:
  - forces `mx_ack_o` = 1 to the granted master;
  - drives `mx_dat_o` = 16'hFFFF;
  - pulses `arb_err_o`.
- The counter then clears. This prevents an undecoded I/O address from hanging the CPU.

Without `ARB_TIMEOUT_EN`:
- No counter is built and `arb_err_o` is tied 0.
- An unacked cycle holds the grant indefinitely.

## Test plan
- Reset then idle: `wb_rst_i` high 3 clocks, then all inputs 0 -> `gnt_o` = 00, `s_cyc_o` = 0, both acks 0.
- Single master: M0 read at adr 19'h00100, slave acks after 2 clocks with 16'h1234 -> `gnt_o` = 01 one clock after `cyc`, `m0_dat_o` = 16'h1234 with `m0_ack_o`, then IDLE after `cyc` drops.
- Simultaneous requests, three times:
  - 1st: M0 wins;
  - 2nd: M1 wins;
  - 3rd: M0 wins (alternation).
- Locked burst: M1 holds `cyc` over 3 stb/ack pairs while M0 requests -> `gnt_o` stays 10 and `m0_ack_o` stays 0. On M1 `cyc` drop, `gnt_o` = 01 next clock with no IDLE clock.
- Reset mid-cycle: `wb_rst_i` during an M0 transfer with ack pending -> next clock `gnt_o` = 00 and `s_stb_o` = 0, no ack to M0.
- `ARB_TIMEOUT_EN` with `TIMEOUT` = 8: M0 I/O read with `s_ack_i` held 0 -> `m0_ack_o` and `arb_err_o` high for exactly 1 clock, 8 clocks after `stb`, with `m0_dat_o` = 16'hFFFF. Without the macro: no ack after 100 clocks.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant on cyc, bus held for the whole cycle.
// Optional slave-response watchdog enabled by defining ARB_TIMEOUT_EN.
module wb_arbiter2 #(
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [18:0] m0_adr_i,
   input  logic [15:0] m0_dat_i,
   input  logic [1:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_tga_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic [15:0] m0_dat_o,
   output logic        m0_ack_o,
   input  logic [18:0] m1_adr_i,
   input  logic [15:0] m1_dat_i,
   input  logic [1:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_tga_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic [15:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic [18:0] s_adr_o,
   output logic [15:0] s_dat_o,
   output logic [1:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_tga_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic [15:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o,
   output logic        arb_err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic        r_prio;
   logic        w_g0;
   logic        w_g1;
   logic        w_timeout;
   logic [15:0] w_rdData;

   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_badTimeout
      $error("wb_arbiter2: TIMEOUT must lie in 2..65535");
   end

   // r_prio names the master that wins a tie: 0 = M0, 1 = M1
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) w_nextState = r_prio ? GNT1 : GNT0;
            else if (m0_cyc_i)        w_nextState = GNT0;
            else if (m1_cyc_i)        w_nextState = GNT1;
         end
         GNT0:    if (!m0_cyc_i) w_nextState = m1_cyc_i ? GNT1 : IDLE;
         GNT1:    if (!m1_cyc_i) w_nextState = m0_cyc_i ? GNT0 : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= IDLE;
         r_prio  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_nextState == GNT0 && r_state != GNT0)      r_prio <= 1'b1;
         else if (w_nextState == GNT1 && r_state != GNT1) r_prio <= 1'b0;
      end
   end

   assign w_g0  = (r_state == GNT0);
   assign w_g1  = (r_state == GNT1);
   assign gnt_o = {w_g1, w_g0};

   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_tga_o = 1'b0;
      s_stb_o = 1'b0;
      s_cyc_o = 1'b0;
      if (w_g0) begin
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
         s_sel_o = m0_sel_i;
         s_we_o  = m0_we_i;
         s_tga_o = m0_tga_i;
         s_stb_o = m0_stb_i;
         s_cyc_o = m0_cyc_i;
      end else if (w_g1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_sel_o = m1_sel_i;
         s_we_o  = m1_we_i;
         s_tga_o = m1_tga_i;
         s_stb_o = m1_stb_i;
         s_cyc_o = m1_cyc_i;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT);
   logic [15:0] r_wdCnt;

   // Watchdog fakes an all-ones ack so an undecoded access cannot hang the master
   assign w_timeout = s_stb_o && !s_ack_i && (r_wdCnt == TIMEOUT_LIMIT);
   assign arb_err_o = w_timeout;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !s_stb_o || s_ack_i || w_timeout || (w_nextState != r_state))
         r_wdCnt <= '0;
      else
         r_wdCnt <= r_wdCnt + 16'd1;
   end
`else
   assign w_timeout = 1'b0;
   assign arb_err_o = 1'b0;
`endif

   assign w_rdData = w_timeout ? 16'hFFFF : s_dat_i;
   assign m0_dat_o = w_rdData;
   assign m1_dat_o = w_rdData;
   assign m0_ack_o = (s_ack_i || w_timeout) && w_g0;
   assign m1_ack_o = (s_ack_i || w_timeout) && w_g1;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: a scoreboard of expected acks plus per-scenario checks.
// Exercises the watchdog path when ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic [18:0] m0_adr_i, m1_adr_i, s_adr_o;
   logic [15:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic [1:0]  m0_sel_i, m1_sel_i, s_sel_o, gnt_o;
   logic        m0_we_i, m0_tga_i, m0_stb_i, m0_cyc_i, m0_ack_o;
   logic        m1_we_i, m1_tga_i, m1_stb_i, m1_cyc_i, m1_ack_o;
   logic        s_we_o, s_tga_o, s_stb_o, s_cyc_o, s_ack_i, arb_err_o;

   typedef struct {
      int          master;
      logic [15:0] data;
      logic        err;
   } exp_t;

   exp_t expQ[$];
   exp_t monItem;
   logic [1:0]  monWant;
   logic [15:0] monDat;
   int nChecks = 0;
   int nFail = 0;
   int benchPrio = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_arbiter2 #(.TIMEOUT(8)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
      .m0_tga_i(m0_tga_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
      .m1_tga_i(m1_tga_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_tga_o(s_tga_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .gnt_o(gnt_o), .arb_err_o(arb_err_o)
   );

   // Every ack a master sees must match the oldest outstanding expectation
   always @(negedge wb_clk_i) begin
      if (m0_ack_o || m1_ack_o) begin
         nChecks++;
         if (expQ.size() == 0) begin
            nFail++;
            $display("[TB] FAIL unexpected_ack: got m1/m0 ack %b%b, expected no ack", m1_ack_o, m0_ack_o);
         end else begin
            monItem = expQ.pop_front();
            monWant = (monItem.master == 0) ? 2'b01 : 2'b10;
            monDat  = (monItem.master == 0) ? m0_dat_o : m1_dat_o;
            if ({m1_ack_o, m0_ack_o} !== monWant || monDat !== monItem.data || arb_err_o !== monItem.err) begin
               nFail++;
               $display("[TB] FAIL scoreboard_ack: got ack=%b dat=%h err=%b, expected ack=%b dat=%h err=%b",
                        {m1_ack_o, m0_ack_o}, monDat, arb_err_o, monWant, monItem.data, monItem.err);
            end
         end
      end
   end

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic idleInputs();
      m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_tga_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
      m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_tga_i = 0; m1_stb_i = 0; m1_cyc_i = 0;
      s_dat_i = '0; s_ack_i = 0;
   endtask

   task automatic test_reset();
      idleInputs();
      wb_rst_i = 1;
      repeat (3) step();
      wb_rst_i = 0;
      benchPrio = 0;
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b00) begin nFail++; $display("[TB] FAIL reset_gnt: got %b, expected 00", gnt_o); end
      nChecks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin nFail++; $display("[TB] FAIL reset_slave: got cyc=%b stb=%b, expected 0 0", s_cyc_o, s_stb_o); end
      nChecks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || arb_err_o !== 1'b0) begin nFail++; $display("[TB] FAIL reset_acks: got %b%b err=%b, expected 00 err=0", m1_ack_o, m0_ack_o, arb_err_o); end
      step();
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b00 || s_adr_o !== 19'h0) begin nFail++; $display("[TB] FAIL idle_bus: got gnt=%b adr=%h, expected 00 0", gnt_o, s_adr_o); end
   endtask

   task automatic test_single_master();
      step();
      m0_adr_i = 19'h00100; m0_sel_i = 2'b11; m0_cyc_i = 1; m0_stb_i = 1;
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b00) begin nFail++; $display("[TB] FAIL single_pre_gnt: got %b, expected 00", gnt_o); end
      step();
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b01) begin nFail++; $display("[TB] FAIL single_gnt: got %b, expected 01", gnt_o); end
      nChecks++; if (s_adr_o !== 19'h00100 || s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin nFail++; $display("[TB] FAIL single_route: got adr=%h stb=%b cyc=%b, expected 00100 1 1", s_adr_o, s_stb_o, s_cyc_o); end
      step();
      @(negedge wb_clk_i);
      nChecks++; if (m0_ack_o !== 1'b0) begin nFail++; $display("[TB] FAIL single_early_ack: got %b, expected 0", m0_ack_o); end
      step();
      s_ack_i = 1; s_dat_i = 16'h1234;
      expQ.push_back('{0, 16'h1234, 1'b0});
      benchPrio = 1;
      @(negedge wb_clk_i);
      step();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b01) begin nFail++; $display("[TB] FAIL single_hold: got %b, expected 01", gnt_o); end
      step();
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin nFail++; $display("[TB] FAIL single_release: got gnt=%b cyc=%b, expected 00 0", gnt_o, s_cyc_o); end
   endtask

   task automatic test_round_robin();
      int winner;
      logic [1:0] want;
      wb_rst_i = 1;
      step();
      wb_rst_i = 0;
      benchPrio = 0;
      for (int r = 0; r < 3; r++) begin
         winner = benchPrio;
         want = (winner == 0) ? 2'b01 : 2'b10;
         step();
         m0_adr_i = 19'h00200; m1_adr_i = 19'h40300;
         m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
         step();
         s_ack_i = 1; s_dat_i = 16'h5A00 + 16'(r);
         expQ.push_back('{winner, 16'h5A00 + 16'(r), 1'b0});
         benchPrio = 1 - winner;
         @(negedge wb_clk_i);
         nChecks++; if (gnt_o !== want) begin nFail++; $display("[TB] FAIL rr_gnt_%0d: got %b, expected %b", r, gnt_o, want); end
         nChecks++; if (s_adr_o !== ((winner == 0) ? 19'h00200 : 19'h40300)) begin nFail++; $display("[TB] FAIL rr_adr_%0d: got %h", r, s_adr_o); end
         step();
         s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
         step();
         @(negedge wb_clk_i);
         nChecks++; if (gnt_o !== 2'b00) begin nFail++; $display("[TB] FAIL rr_idle_%0d: got %b, expected 00", r, gnt_o); end
      end
   endtask

   task automatic test_locked_burst();
      step();
      m1_adr_i = 19'h12345; m1_we_i = 1; m1_dat_i = 16'hC0DE; m1_cyc_i = 1; m1_stb_i = 1;
      m0_adr_i = 19'h00777;
      @(negedge wb_clk_i);
      for (int i = 0; i < 3; i++) begin
         step();
         m0_cyc_i = 1; m0_stb_i = 1; m1_stb_i = 1;
         s_ack_i = 1; s_dat_i = 16'hA000 + 16'(i);
         expQ.push_back('{1, 16'hA000 + 16'(i), 1'b0});
         @(negedge wb_clk_i);
         nChecks++; if (gnt_o !== 2'b10 || s_adr_o !== 19'h12345 || s_we_o !== 1'b1) begin nFail++; $display("[TB] FAIL burst_gnt_%0d: got gnt=%b adr=%h we=%b, expected 10 12345 1", i, gnt_o, s_adr_o, s_we_o); end
         step();
         s_ack_i = 0; m1_stb_i = 0;
         @(negedge wb_clk_i);
         nChecks++; if (gnt_o !== 2'b10 || m0_ack_o !== 1'b0 || s_stb_o !== 1'b0) begin nFail++; $display("[TB] FAIL burst_lock_%0d: got gnt=%b m0_ack=%b stb=%b, expected 10 0 0", i, gnt_o, m0_ack_o, s_stb_o); end
      end
      benchPrio = 0;
      step();
      m1_cyc_i = 0; m1_we_i = 0;
      step();
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b01 || s_adr_o !== 19'h00777 || s_stb_o !== 1'b1) begin nFail++; $display("[TB] FAIL handover: got gnt=%b adr=%h stb=%b, expected 01 00777 1", gnt_o, s_adr_o, s_stb_o); end
      benchPrio = 1;
      step();
      s_ack_i = 1; s_dat_i = 16'hBEEF;
      expQ.push_back('{0, 16'hBEEF, 1'b0});
      step();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      step();
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b00) begin nFail++; $display("[TB] FAIL burst_release: got %b, expected 00", gnt_o); end
   endtask

   task automatic test_reset_midcycle();
      step();
      m0_adr_i = 19'h00400; m0_cyc_i = 1; m0_stb_i = 1;
      step();
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b01 || s_stb_o !== 1'b1) begin nFail++; $display("[TB] FAIL mid_pre_gnt: got gnt=%b stb=%b, expected 01 1", gnt_o, s_stb_o); end
      step();
      wb_rst_i = 1;
      step();
      s_ack_i = 1; s_dat_i = 16'h7777;
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b00 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin nFail++; $display("[TB] FAIL mid_reset: got gnt=%b stb=%b cyc=%b, expected 00 0 0", gnt_o, s_stb_o, s_cyc_o); end
      nChecks++; if (m0_ack_o !== 1'b0) begin nFail++; $display("[TB] FAIL mid_no_ack: got %b, expected 0", m0_ack_o); end
      step();
      wb_rst_i = 0; s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      benchPrio = 0;
      step();
   endtask

   task automatic test_timeout();
      int ackCount;
      ackCount = 0;
      step();
      m0_adr_i = 19'h003F8; m0_tga_i = 1; m0_cyc_i = 1; m0_stb_i = 1;
      step();
      @(negedge wb_clk_i);
      nChecks++; if (s_stb_o !== 1'b1 || s_tga_o !== 1'b1) begin nFail++; $display("[TB] FAIL wd_start: got stb=%b tga=%b, expected 1 1", s_stb_o, s_tga_o); end
`ifdef ARB_TIMEOUT_EN
      expQ.push_back('{0, 16'hFFFF, 1'b1});
      for (int k = 1; k < 8; k++) begin
         step();
         @(negedge wb_clk_i);
         if (m0_ack_o || arb_err_o) ackCount++;
      end
      nChecks++; if (ackCount !== 0) begin nFail++; $display("[TB] FAIL wd_early: got %0d early acks, expected 0", ackCount); end
      step();
      @(negedge wb_clk_i);
      nChecks++; if (m0_ack_o !== 1'b1 || arb_err_o !== 1'b1) begin nFail++; $display("[TB] FAIL wd_fire: got ack=%b err=%b, expected 1 1", m0_ack_o, arb_err_o); end
      step();
      m0_cyc_i = 0; m0_stb_i = 0; m0_tga_i = 0;
      @(negedge wb_clk_i);
      nChecks++; if (m0_ack_o !== 1'b0 || arb_err_o !== 1'b0) begin nFail++; $display("[TB] FAIL wd_pulse_width: got ack=%b err=%b, expected 0 0", m0_ack_o, arb_err_o); end
`else
      for (int k = 0; k < 100; k++) begin
         step();
         @(negedge wb_clk_i);
         if (m0_ack_o || arb_err_o) ackCount++;
      end
      nChecks++; if (ackCount !== 0) begin nFail++; $display("[TB] FAIL no_wd_ack: got %0d acks, expected 0", ackCount); end
      nChecks++; if (gnt_o !== 2'b01) begin nFail++; $display("[TB] FAIL no_wd_hold: got %b, expected 01", gnt_o); end
      step();
      m0_cyc_i = 0; m0_stb_i = 0; m0_tga_i = 0;
`endif
      step();
      @(negedge wb_clk_i);
      nChecks++; if (gnt_o !== 2'b00) begin nFail++; $display("[TB] FAIL wd_release: got %b, expected 00", gnt_o); end
   endtask

   initial begin
      idleInputs();
      wb_rst_i = 1;
      test_reset();
      test_single_master();
      test_round_robin();
      test_locked_burst();
      test_reset_midcycle();
      test_timeout();
      repeat (2) step();
      nChecks++;
      if (expQ.size() != 0) begin
         nFail++;
         $display("[TB] FAIL pending_acks: got %0d outstanding, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
